// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream little-endian into byte-strobed 32-bit imem writes (start/base_addr/len/abort/s_* in; s_ready, w_*_imem, busy, done, err out)
module imem_loader #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              w_en_imem,
  output logic [ADDR_W-1:0] w_addr_imem,
  output logic [31:0]       w_data_imem,
  output logic [3:0]        w_strb_imem,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] MEM_BYTES = {1'b1, {ADDR_W{1'b0}}};
  state_t state, state_n;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0] rem;
  logic [31:0] pbuf, buf_n;
  logic [3:0] pstrb, strb_n;
  logic xfer, last, complete, range_err;
  always_comb begin
    xfer = s_valid & s_ready;
    last = rem == 1;
    complete = xfer & ~abort & ((cur[1:0] == 2'd3) | last);
    range_err = ({1'b0, base_addr} + len) > MEM_BYTES;
    buf_n = pbuf | ({24'd0, s_data} << {cur[1:0], 3'b000});
    strb_n = pstrb | (4'b0001 << cur[1:0]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? ((range_err || len == '0) ? DONE : LOAD) : IDLE)
            : state == LOAD ? ((abort || (xfer && last)) ? DONE : LOAD)
            : IDLE;
  end
  always_comb begin
    s_ready = state == LOAD;
    busy = state == LOAD;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
      rem <= '0;
      pbuf <= '0;
      pstrb <= '0;
      err <= 1'b0;
      w_en_imem <= 1'b0;
      w_addr_imem <= '0;
      w_data_imem <= '0;
      w_strb_imem <= '0;
    end else begin
      w_en_imem <= complete;
      if (complete) begin
        w_addr_imem <= {cur[ADDR_W-1:2], 2'b00};
        w_data_imem <= buf_n;
        w_strb_imem <= strb_n;
      end
      if (state == IDLE && start) begin
        err <= range_err;
        cur <= base_addr;
        rem <= len;
        pbuf <= '0;
        pstrb <= '0;
      end else if (state == LOAD) begin
        if (abort) begin
          err <= 1'b1;
          pbuf <= '0;
          pstrb <= '0;
        end else if (xfer) begin
          cur <= cur + 1'b1;
          rem <= rem - 1'b1;
          pbuf <= complete ? '0 : buf_n;
          pstrb <= complete ? '0 : strb_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 0, rst = 1, start = 0, abort = 0, s_valid = 0;
  logic [6:0] base_addr = '0;
  logic [7:0] len = '0;
  logic [7:0] s_data = '0;
  logic s_ready, w_en_imem, busy, done, err;
  logic [6:0] w_addr_imem;
  logic [31:0] w_data_imem;
  logic [3:0] w_strb_imem;
  int ncmp = 0, nerr = 0;
  int nw = 0, ndone = 0, ndw = 0;
  logic [6:0] wa[64];
  logic [31:0] wd[64];
  logic [3:0] ws[64];
  logic [7:0] bytes_q[8];

  imem_loader #(.ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .w_en_imem(w_en_imem), .w_addr_imem(w_addr_imem), .w_data_imem(w_data_imem),
    .w_strb_imem(w_strb_imem), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en_imem && nw < 64) begin
      wa[nw] = w_addr_imem;
      wd[nw] = w_data_imem;
      ws[nw] = w_strb_imem;
      nw++;
    end
    if (done) ndone++;
    if (done && w_en_imem) ndw++;
  end

  task automatic load(input logic [6:0] b, input logic [7:0] l, input int n, input bit gaps, input int abort_after);
    int i = 0, t = 0;
    bit acc;
    @(negedge clk);
    base_addr = b; len = l; start = 1;
    @(negedge clk);
    start = 0;
    while (i < n && t < 300) begin
      if (i == abort_after) begin
        abort = 1; s_valid = 1; s_data = 8'hEE;
        @(negedge clk);
        abort = 0; s_valid = 0;
        break;
      end
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data = bytes_q[i];
      acc = s_valid && s_ready;
      @(negedge clk);
      if (acc) i++;
      t++;
    end
    s_valid = 0;
    if (t >= 300) begin
      ncmp++; nerr++;
      $display("FAIL load_timeout accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic set_case1;
    bytes_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  task automatic check_case1(input int w0, input int d0, input int dw0, input string nm);
    logic [6:0] ea[2] = '{7'h00, 7'h04};
    logic [31:0] ed[2] = '{32'h00000013, 32'h00100093};
    ncmp++;
    if (nw - w0 !== 2) begin nerr++; $display("FAIL %s_wcount got=%0d exp=2", nm, nw - w0); end
    for (int k = 0; k < 2; k++) begin
      ncmp++;
      if ({wa[w0+k], wd[w0+k], ws[w0+k]} !== {ea[k], ed[k], 4'b1111}) begin
        nerr++;
        $display("FAIL %s_w%0d got=%h/%h/%b exp=%h/%h/1111", nm, k, wa[w0+k], wd[w0+k], ws[w0+k], ea[k], ed[k]);
      end
    end
    ncmp++;
    if ({ndone - d0, ndw - dw0} !== {32'd1, 32'd1}) begin
      nerr++; $display("FAIL %s_done got=%0d/%0d exp=1/1", nm, ndone - d0, ndw - dw0);
    end
    ncmp++;
    if (err !== 1'b0) begin nerr++; $display("FAIL %s_err got=%b exp=0", nm, err); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    ncmp++;
    if ({s_ready, w_en_imem, busy, done, err, w_addr_imem, w_data_imem, w_strb_imem} !== '0) begin
      nerr++; $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%h/%h/%b exp=all0", s_ready, w_en_imem, busy, done, err, w_addr_imem, w_data_imem, w_strb_imem);
    end
    rst = 0;
  endtask

  task automatic test_case1(input bit gaps, input string nm);
    int w0 = nw, d0 = ndone, dw0 = ndw;
    set_case1();
    load(7'h00, 8'd8, 8, gaps, -1);
    repeat (3) @(negedge clk);
    check_case1(w0, d0, dw0, nm);
  endtask

  task automatic test_unaligned;
    int w0 = nw;
    bytes_q[0] = 8'hAA; bytes_q[1] = 8'hBB; bytes_q[2] = 8'hCC; bytes_q[3] = 8'hDD;
    load(7'h05, 8'd4, 4, 0, -1);
    repeat (3) @(negedge clk);
    ncmp++;
    if (nw - w0 !== 2) begin nerr++; $display("FAIL unal_wcount got=%0d exp=2", nw - w0); end
    ncmp++;
    if ({wa[w0], wd[w0], ws[w0]} !== {7'h04, 32'hCCBBAA00, 4'b1110}) begin
      nerr++; $display("FAIL unal_w0 got=%h/%h/%b exp=04/ccbbaa00/1110", wa[w0], wd[w0], ws[w0]);
    end
    ncmp++;
    if ({wa[w0+1], wd[w0+1], ws[w0+1]} !== {7'h08, 32'h000000DD, 4'b0001}) begin
      nerr++; $display("FAIL unal_w1 got=%h/%h/%b exp=08/000000dd/0001", wa[w0+1], wd[w0+1], ws[w0+1]);
    end
    ncmp++;
    if (err !== 1'b0) begin nerr++; $display("FAIL unal_err got=%b exp=0", err); end
  endtask

  task automatic test_top_edge;
    int w0 = nw;
    bytes_q[0] = 8'h01; bytes_q[1] = 8'h02; bytes_q[2] = 8'h03; bytes_q[3] = 8'h04;
    load(7'h7C, 8'd4, 4, 0, -1);
    repeat (3) @(negedge clk);
    ncmp++;
    if ({nw - w0, wa[w0], wd[w0], ws[w0], err} !== {32'd1, 7'h7C, 32'h04030201, 4'b1111, 1'b0}) begin
      nerr++; $display("FAIL top_edge got=%0d/%h/%h/%b/%b exp=1/7c/04030201/1111/0", nw - w0, wa[w0], wd[w0], ws[w0], err);
    end
  endtask

  task automatic test_len0_and_range;
    int w0 = nw;
    @(negedge clk);
    base_addr = 7'h10; len = 8'd0; start = 1;
    @(negedge clk);
    start = 0;
    ncmp++;
    if ({done, err, busy} !== 3'b100) begin nerr++; $display("FAIL len0_done got=%b%b%b exp=100", done, err, busy); end
    @(negedge clk);
    ncmp++;
    if (done !== 1'b0) begin nerr++; $display("FAIL len0_pulse got=%b exp=0", done); end
    base_addr = 7'h7C; len = 8'd8; start = 1;
    @(negedge clk);
    start = 0;
    ncmp++;
    if ({done, err, busy} !== 3'b110) begin nerr++; $display("FAIL range_done got=%b%b%b exp=110", done, err, busy); end
    repeat (3) @(negedge clk);
    ncmp++;
    if ({nw - w0, err} !== {32'd0, 1'b1}) begin nerr++; $display("FAIL range_nowrite got=%0d/%b exp=0/1", nw - w0, err); end
  endtask

  task automatic test_abort;
    int w0 = nw, d0 = ndone;
    set_case1();
    load(7'h00, 8'd8, 8, 0, 2);
    repeat (3) @(negedge clk);
    ncmp++;
    if ({nw - w0, ndone - d0, err, busy} !== {32'd0, 32'd1, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL abort got=%0d/%0d/%b/%b exp=0/1/1/0", nw - w0, ndone - d0, err, busy);
    end
    base_addr = 7'h00; len = 8'd0; start = 1;
    @(negedge clk);
    start = 0;
    ncmp++;
    if ({err, done} !== 2'b01) begin nerr++; $display("FAIL abort_errclr got=%b%b exp=01", err, done); end
  endtask

  task automatic test_midreset;
    int w0 = nw;
    set_case1();
    load(7'h00, 8'd8, 3, 0, -1);
    rst = 1;
    #1;
    ncmp++;
    if ({s_ready, w_en_imem, busy, done, err, w_addr_imem, w_data_imem, w_strb_imem} !== '0) begin
      nerr++; $display("FAIL midrst_outputs got=%b/%b/%b/%b/%b/%h/%h/%b exp=all0", s_ready, w_en_imem, busy, done, err, w_addr_imem, w_data_imem, w_strb_imem);
    end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    ncmp++;
    if (nw - w0 !== 0) begin nerr++; $display("FAIL midrst_nowrite got=%0d exp=0", nw - w0); end
    test_case1(0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_case1(0, "case1");
    test_unaligned();
    test_case1(1, "gaps");
    test_top_edge();
    test_len0_and_range();
    test_abort();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
